regfile_scoreboard: RTL and testbench



---
 rtl/cpu_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU register-file slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default data width, default register count, index of the hardwired-zero register.
package cpu_pkg;

  // Default architectural data width in bits.
  localparam int CPU_XLEN = 32;

  // Default number of architectural registers (power of two, at least 2).
  localparam int CPU_NREG = 32;

  // Register index that always reads zero and can never be marked busy.
  localparam int REG_ZERO = 0;

endpackage : cpu_pkg

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running count of the set bits.
// Latency: busy bits and count update on the clock edge after issue/writeback/flush.
// Backpressure: none; callers stall on the busy outputs themselves.
// Ports:
//   clk, rstn           clock and asynchronous active-low reset
//   issue_en, issue_rd  mark a destination busy
//   we, rw              writeback clears the busy bit of rw
//   flush               clears every busy bit and the count
//   busy                per-register busy vector (bit 0 is always 0)
//   pending_cnt         number of busy bits currently set
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter  int NREG = CPU_NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_rd,
  input  logic          we,
  input  logic [AW-1:0] rw,
  input  logic          flush,
  output logic [NREG-1:0] busy,
  output logic [AW:0]   pending_cnt
);

  logic          set_hit;
  logic          clr_hit;
  logic [AW:0]   cnt_next;

  // Only real transitions move the counter: issuing to an already-busy
  // register, or writing back to an idle one, leaves the population unchanged.
  // A writeback that collides with an issue to the same register loses,
  // because the newer producer is still outstanding.
  always_comb begin
    set_hit = issue_en && (issue_rd != AW'(REG_ZERO)) && !busy[issue_rd];
    clr_hit = we && (rw != AW'(REG_ZERO)) && busy[rw] &&
              !(issue_en && (issue_rd == rw));
    unique case ({set_hit, clr_hit})
      2'b10:   cnt_next = pending_cnt + (AW+1)'(1);
      2'b01:   cnt_next = pending_cnt - (AW+1)'(1);
      default: cnt_next = pending_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else if (flush) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      if (clr_hit) busy[rw]       <= 1'b0;
      if (set_hit) busy[issue_rd] <= 1'b1;
      pending_cnt <= cnt_next;
    end
  end

endmodule : rf_scoreboard

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file (2 read ports, 1 debug read, 1 write) with pending-write scoreboard.
// Latency: reads combinational (0 cycles), optional same-cycle write forwarding; writes land at the next edge.
// Backpressure: none; hazard logic consumes busy_a/busy_b and stalls upstream.
// Ports:
//   clk, rstn                clock and asynchronous active-low reset
//   ra/rb -> rdata_a/rdata_b architectural reads, busy_a/busy_b outstanding-write flags
//   we, rw, wdata            writeback port (rw = 0 ignored)
//   issue_en, issue_rd       destination of the issuing instruction becomes busy
//   flush                    clears all busy bits (data write still happens)
//   dbg_addr -> dbg_data     debug read of the stored value, never forwarded
//   pending_cnt              number of busy registers
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter  int XLEN   = CPU_XLEN,
  parameter  int NREG   = CPU_NREG,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW-1:0]   ra,
  input  logic [AW-1:0]   rb,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            we,
  input  logic [AW-1:0]   rw,
  input  logic [XLEN-1:0] wdata,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [AW:0]     pending_cnt
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy_vec;
  logic            wr_hit;
  logic            fwd_a;
  logic            fwd_b;

  // Storage: every entry clears on reset; register 0 is never written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (rw != AW'(REG_ZERO))) begin
      mem[rw] <= wdata;
    end
  end

  rf_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk         (clk),
    .rstn        (rstn),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .we          (we),
    .rw          (rw),
    .flush       (flush),
    .busy        (busy_vec),
    .pending_cnt (pending_cnt)
  );

  // Forwarding is qualified with rstn so that reads stay at zero while reset
  // is held, even if the writeback port is active (that write is discarded).
  always_comb begin
    wr_hit = rstn && we && (rw != AW'(REG_ZERO));
    fwd_a  = (BYPASS != 0) && wr_hit && (rw == ra);
    fwd_b  = (BYPASS != 0) && wr_hit && (rw == rb);
  end

  // A forwarded operand is by definition no longer pending, so its busy flag
  // is suppressed along with the data substitution.
  always_comb begin
    rdata_a = '0;
    busy_a  = 1'b0;
    if (ra != AW'(REG_ZERO)) begin
      if (fwd_a) begin
        rdata_a = wdata;
      end else begin
        rdata_a = mem[ra];
        busy_a  = busy_vec[ra];
      end
    end
  end

  always_comb begin
    rdata_b = '0;
    busy_b  = 1'b0;
    if (rb != AW'(REG_ZERO)) begin
      if (fwd_b) begin
        rdata_b = wdata;
      end else begin
        rdata_b = mem[rb];
        busy_b  = busy_vec[rb];
      end
    end
  end

  always_comb begin
    dbg_data = '0;
    if (dbg_addr != AW'(REG_ZERO)) dbg_data = mem[dbg_addr];
  end

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic [AW-1:0]   ra, rb, rw, issue_rd, dbg_addr;
  logic            we, issue_en, flush;
  logic [XLEN-1:0] wdata;

  logic [XLEN-1:0] rdata_a1, rdata_b1, dbg_data1;
  logic            busy_a1, busy_b1;
  logic [AW:0]     pend1;
  logic [XLEN-1:0] rdata_a0, rdata_b0, dbg_data0;
  logic            busy_a0, busy_b0;
  logic [AW:0]     pend0;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rstn(rstn), .ra(ra), .rb(rb),
    .rdata_a(rdata_a1), .rdata_b(rdata_b1), .busy_a(busy_a1), .busy_b(busy_b1),
    .we(we), .rw(rw), .wdata(wdata), .issue_en(issue_en), .issue_rd(issue_rd),
    .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data1), .pending_cnt(pend1)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_dut_nobyp (
    .clk(clk), .rstn(rstn), .ra(ra), .rb(rb),
    .rdata_a(rdata_a0), .rdata_b(rdata_b0), .busy_a(busy_a0), .busy_b(busy_b0),
    .we(we), .rw(rw), .wdata(wdata), .issue_en(issue_en), .issue_rd(issue_rd),
    .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data0), .pending_cnt(pend0)
  );

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_mem  [NREG];
  bit              m_busy [NREG];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 0;
      end
    end else begin
      if (we && rw != 0) m_mem[rw] = wdata;
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
      end else begin
        // clear first, then set: a same-register issue overrides the writeback
        if (we && rw != 0) m_busy[rw] = 0;
        if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1;
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && rstn && we && rw == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && rstn && we && rw == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("byp.rdata_a", 64'(rdata_a1), 64'(exp_rd(ra, 1)));
      chk("byp.rdata_b", 64'(rdata_b1), 64'(exp_rd(rb, 1)));
      chk("byp.busy_a",  64'(busy_a1),  64'(exp_busy(ra, 1)));
      chk("byp.busy_b",  64'(busy_b1),  64'(exp_busy(rb, 1)));
      chk("byp.dbg",     64'(dbg_data1), 64'(exp_rd(dbg_addr, 0)));
      chk("byp.pending", 64'(pend1),    64'(exp_cnt()));
      chk("nob.rdata_a", 64'(rdata_a0), 64'(exp_rd(ra, 0)));
      chk("nob.rdata_b", 64'(rdata_b0), 64'(exp_rd(rb, 0)));
      chk("nob.busy_a",  64'(busy_a0),  64'(exp_busy(ra, 0)));
      chk("nob.busy_b",  64'(busy_b0),  64'(exp_busy(rb, 0)));
      chk("nob.dbg",     64'(dbg_data0), 64'(exp_rd(dbg_addr, 0)));
      chk("nob.pending", 64'(pend0),    64'(exp_cnt()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; rw = '0; wdata = '0; issue_en = 0; issue_rd = '0; flush = 0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    rstn = 0;
    ra = '0; rb = '0; dbg_addr = '0;
    idle();
    step();
    cmp_en = 1;
    // drive the write port during reset: it must not leak through
    we = 1; rw = 5'd5; wdata = 32'hFFFF_FFFF; ra = 5'd5;
    #2;
    chk("rst.rdata_a_held", 64'(rdata_a1), 64'h0);
    step();
    idle();
    rstn = 1;

    // reset: every address reads zero and not busy
    for (int i = 0; i < NREG; i++) begin
      ra = AW'(i); rb = AW'(NREG - 1 - i); dbg_addr = AW'(i);
      step();
    end
    chk("rst.pending", 64'(pend1), 64'h0);
    chk("rst.dbg31",   64'(dbg_data1), 64'h0);

    // same-cycle write with read of the same register
    we = 1; rw = 5'd5; wdata = 32'hDEADBEEF; ra = 5'd5; rb = 5'd0;
    #2;
    chk("byp.same_cycle",   64'(rdata_a1), 64'hDEADBEEF);
    chk("nobyp.same_cycle", 64'(rdata_a0), 64'h0);
    step();
    idle();
    dbg_addr = 5'd5;
    #2;
    chk("byp.dbg_next",   64'(dbg_data1), 64'hDEADBEEF);
    chk("nobyp.next",     64'(rdata_a0),  64'hDEADBEEF);
    step();

    // writes and issues to x0 are ignored
    we = 1; rw = 5'd0; wdata = 32'h1234; issue_en = 1; issue_rd = 5'd0; ra = 5'd0;
    #2;
    chk("x0.rdata", 64'(rdata_a1), 64'h0);
    chk("x0.busy",  64'(busy_a1),  64'h0);
    step();
    idle();
    #2;
    chk("x0.pending", 64'(pend1), 64'h0);
    chk("x0.rdata_after", 64'(rdata_a1), 64'h0);

    // issue 7, 9; then issue 7 colliding with writeback 7
    step();
    issue_en = 1; issue_rd = 5'd7;
    step();
    issue_rd = 5'd9;
    step();
    idle(); ra = 5'd7; rb = 5'd9;
    #2;
    chk("sb.busy7", 64'(busy_a1), 64'h1);
    chk("sb.busy9", 64'(busy_b1), 64'h1);
    chk("sb.pend2", 64'(pend1),   64'h2);
    step();
    issue_en = 1; issue_rd = 5'd7; we = 1; rw = 5'd7; wdata = 32'h77;
    step();
    idle();
    #2;
    chk("sb.issue_wins", 64'(busy_a1), 64'h1);
    chk("sb.pend_hold",  64'(pend1),   64'h2);
    chk("sb.wb_data",    64'(rdata_a1), 64'h77);

    // flush with a simultaneous data write
    step();
    flush = 1;
    step();
    flush = 0; issue_en = 1; issue_rd = 5'd3;
    step();
    issue_rd = 5'd4;
    step();
    issue_rd = 5'd8;
    step();
    idle();
    #2;
    chk("fl.pend3", 64'(pend1), 64'h3);
    step();
    flush = 1; we = 1; rw = 5'd3; wdata = 32'd5;
    step();
    idle(); dbg_addr = 5'd3; ra = 5'd3; rb = 5'd8;
    #2;
    chk("fl.pend0",   64'(pend1),     64'h0);
    chk("fl.dbg3",    64'(dbg_data1), 64'h5);
    chk("fl.busy3",   64'(busy_a1),   64'h0);
    chk("fl.busy8",   64'(busy_b1),   64'h0);

    // asynchronous reset mid-cycle
    step();
    we = 1; rw = 5'd12; wdata = 32'hA5A5_A5A5; issue_en = 1; issue_rd = 5'd13;
    step();
    idle(); ra = 5'd12; rb = 5'd13; dbg_addr = 5'd12;
    #2;
    chk("ar.pre_data", 64'(rdata_a1), 64'hA5A5_A5A5);
    chk("ar.pre_busy", 64'(busy_b1),  64'h1);
    chk("ar.pre_pend", 64'(pend1),    64'h1);
    rstn = 0;
    #1;
    chk("ar.data0", 64'(rdata_a1),  64'h0);
    chk("ar.dbg0",  64'(dbg_data1), 64'h0);
    chk("ar.busy0", 64'(busy_b1),   64'h0);
    chk("ar.pend0", 64'(pend1),     64'h0);
    step();
    rstn = 1;
    #2;
    chk("ar.after_pend", 64'(pend1),    64'h0);
    chk("ar.after_data", 64'(rdata_a1), 64'h0);

    // randomized traffic, with occasional mid-cycle resets
    for (int n = 0; n < 1500; n++) begin
      step();
      rstn     = 1;
      ra       = rnd_addr();
      rb       = rnd_addr();
      dbg_addr = rnd_addr();
      we       = ($urandom_range(0, 99) < 45);
      rw       = rnd_addr();
      wdata    = $urandom;
      issue_en = ($urandom_range(0, 99) < 50);
      issue_rd = rnd_addr();
      flush    = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rstn = 0;
      end
    end

    step();
    rstn = 1;
    idle();
    step();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_scoreboard
